// File: rtl/io_control_unit_pkg.sv
// ----------------------------------------------------------------------------
// io_control_unit_pkg
// Shared definitions for the hardwired I/O control sequencer:
//   - opcode constants for the instructions the sequencer understands
//   - opcode field position inside the 32-bit instruction register
//   - width of the retired-instruction counter
//   - FSM state encoding (3-bit binary)
//   - packed bundle of the Datapath control strobes driven by the top
// No ports (package).
// ----------------------------------------------------------------------------
package io_control_unit_pkg;

  localparam logic [4:0] OPC_IN   = 5'b10110;
  localparam logic [4:0] OPC_OUT  = 5'b10111;
  localparam logic [4:0] OPC_NOP  = 5'b11010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_T0     = 3'd1,
    ST_T1     = 3'd2,
    ST_T2     = 3'd3,
    ST_T3     = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  typedef struct packed {
    logic in_port_ack;
    logic out_port_valid;
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic zlow_in;
    logic zlow_out;
    logic pc_in;
    logic md_mux_read;
    logic ram_read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic in_port_out;
    logic out_port_in;
    logic gra;
    logic r_in;
    logic r_out;
    logic run;
    logic illegal;
  } ctl_t;

endpackage

// File: rtl/io_control_unit_if.sv
// ----------------------------------------------------------------------------
// io_control_unit_if
// Bundle between the control sequencer and its Datapath / I/O devices.
//   IR, Stop, InPortvalid          : into the sequencer
//   Datapath strobes, InPortack,
//   OutPortvalid, Run, Illegal,
//   InstrCount                     : out of the sequencer
// Modports:
//   master : the sequencer side (drives the strobes)
//   slave  : the Datapath / device side
// ----------------------------------------------------------------------------
interface io_control_unit_if;
  import io_control_unit_pkg::*;

  logic [31:0]      IR;
  logic             Stop;
  logic             InPortvalid;

  logic             InPortack;
  logic             OutPortvalid;
  logic             PCout;
  logic             MARin;
  logic             IncPC;
  logic             Zlowin;
  logic             Zlowout;
  logic             PCin;
  logic             MDMuxread;
  logic             RAMread;
  logic             MDRin;
  logic             MDRout;
  logic             IRin;
  logic             InPortout;
  logic             OutPortin;
  logic             Gra;
  logic             Rin;
  logic             Rout;
  logic             Run;
  logic             Illegal;
  logic [CNT_W-1:0] InstrCount;

  modport master (
    input  IR, Stop, InPortvalid,
    output InPortack, OutPortvalid,
    output PCout, MARin, IncPC, Zlowin, Zlowout, PCin,
    output MDMuxread, RAMread, MDRin, MDRout, IRin,
    output InPortout, OutPortin, Gra, Rin, Rout,
    output Run, Illegal, InstrCount
  );

  modport slave (
    output IR, Stop, InPortvalid,
    input  InPortack, OutPortvalid,
    input  PCout, MARin, IncPC, Zlowin, Zlowout, PCin,
    input  MDMuxread, RAMread, MDRin, MDRout, IRin,
    input  InPortout, OutPortin, Gra, Rin, Rout,
    input  Run, Illegal, InstrCount
  );

endinterface

// File: rtl/io_control_unit_opcode_decode.sv
// ----------------------------------------------------------------------------
// io_control_unit_opcode_decode
// Purely combinational classification of the 5-bit opcode field.
//   i_opcode     in  5  IR[31:27]
//   o_is_in      out 1  'in Ra'
//   o_is_out     out 1  'out Ra'
//   o_is_nop     out 1  'nop'
//   o_is_halt    out 1  'halt'
//   o_is_illegal out 1  anything else (executed as a nop by the sequencer)
// Exactly one output is high for any opcode.
// ----------------------------------------------------------------------------
module io_control_unit_opcode_decode
  import io_control_unit_pkg::*;
(
  input  logic [4:0] i_opcode,
  output logic       o_is_in,
  output logic       o_is_out,
  output logic       o_is_nop,
  output logic       o_is_halt,
  output logic       o_is_illegal
);

  assign o_is_in      = (i_opcode == OPC_IN);
  assign o_is_out     = (i_opcode == OPC_OUT);
  assign o_is_nop     = (i_opcode == OPC_NOP);
  assign o_is_halt    = (i_opcode == OPC_HALT);
  assign o_is_illegal = ~(o_is_in | o_is_out | o_is_nop | o_is_halt);

endmodule

// File: rtl/io_control_unit.sv
// ----------------------------------------------------------------------------
// io_control_unit
// Hardwired control sequencer for the Datapath: fetch (T0..T2) followed by
// one execute step (T3) for in / out / nop / halt.
//   i_clock  in  1  system clock, all state changes on the rising edge
//   i_clear  in  1  synchronous active-high reset
//   bus      io_control_unit_if.master
//            IR / Stop / InPortvalid in; Datapath strobes, InPortack,
//            OutPortvalid, Run, Illegal and InstrCount out.
// Strobes are decoded from the registered state; only T3 also looks at the
// opcode and InPortvalid, so an IN can stall in T3 waiting for the device.
// ----------------------------------------------------------------------------
module io_control_unit
  import io_control_unit_pkg::*;
(
  input  logic               i_clock,
  input  logic               i_clear,
  io_control_unit_if.master  bus
);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_instr_count;
  ctl_t             w_ctl;
  logic             w_t3_exit;

  logic [4:0]       w_opcode;
  logic             w_unused_ir;
  logic             w_is_in;
  logic             w_is_out;
  logic             w_is_nop;
  logic             w_is_halt;
  logic             w_is_illegal;

  assign w_opcode    = bus.IR[OPC_MSB:OPC_LSB];
  // Operand fields belong to the Datapath; the sequencer never looks at them.
  assign w_unused_ir = ^bus.IR[OPC_LSB-1:0];

  io_control_unit_opcode_decode u_decode (
    .i_opcode     (w_opcode),
    .o_is_in      (w_is_in),
    .o_is_out     (w_is_out),
    .o_is_nop     (w_is_nop),
    .o_is_halt    (w_is_halt),
    .o_is_illegal (w_is_illegal)
  );

  // State register and retired-instruction counter.
  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_state       <= ST_RESET;
      r_instr_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_t3_exit) begin
        r_instr_count <= r_instr_count + CNT_W'(1);
      end
    end
  end

  // Next-state and control decode.
  always_comb begin
    w_state_next = r_state;
    w_t3_exit    = 1'b0;
    w_ctl        = '0;

    case (r_state)
      ST_RESET: begin
        w_state_next = ST_T0;
      end

      ST_T0: begin
        w_ctl.run     = 1'b1;
        w_ctl.pc_out  = 1'b1;
        w_ctl.mar_in  = 1'b1;
        w_ctl.inc_pc  = 1'b1;
        w_ctl.zlow_in = 1'b1;
        w_state_next  = ST_T1;
      end

      ST_T1: begin
        w_ctl.run         = 1'b1;
        w_ctl.zlow_out    = 1'b1;
        w_ctl.pc_in       = 1'b1;
        w_ctl.md_mux_read = 1'b1;
        w_ctl.ram_read    = 1'b1;
        w_ctl.mdr_in      = 1'b1;
        w_state_next      = ST_T2;
      end

      ST_T2: begin
        w_ctl.run     = 1'b1;
        w_ctl.mdr_out = 1'b1;
        w_ctl.ir_in   = 1'b1;
        w_state_next  = ST_T3;
      end

      ST_T3: begin
        w_ctl.run = 1'b1;
        if (w_is_in) begin
          // Register select and port drive stay up through the stall; the
          // register write and the device ack only fire once data is valid.
          w_ctl.in_port_out = 1'b1;
          w_ctl.gra         = 1'b1;
          w_ctl.r_in        = bus.InPortvalid;
          w_ctl.in_port_ack = bus.InPortvalid;
        end else if (w_is_out) begin
          w_ctl.gra            = 1'b1;
          w_ctl.r_out          = 1'b1;
          w_ctl.out_port_in    = 1'b1;
          w_ctl.out_port_valid = 1'b1;
        end else if (w_is_illegal) begin
          w_ctl.illegal = 1'b1;
        end

        // Only a waiting IN holds T3; everything else retires this cycle.
        // Stop is looked at solely on this exit edge.
        w_t3_exit = ~(w_is_in & ~bus.InPortvalid);
        if (w_t3_exit) begin
          w_state_next = (w_is_halt | bus.Stop) ? ST_HALTED : ST_T0;
        end
      end

      ST_HALTED: begin
        w_state_next = ST_HALTED;
      end

      default: begin
        w_state_next = ST_RESET;
      end
    endcase
  end

  assign bus.InPortack    = w_ctl.in_port_ack;
  assign bus.OutPortvalid = w_ctl.out_port_valid;
  assign bus.PCout        = w_ctl.pc_out;
  assign bus.MARin        = w_ctl.mar_in;
  assign bus.IncPC        = w_ctl.inc_pc;
  assign bus.Zlowin       = w_ctl.zlow_in;
  assign bus.Zlowout      = w_ctl.zlow_out;
  assign bus.PCin         = w_ctl.pc_in;
  assign bus.MDMuxread    = w_ctl.md_mux_read;
  assign bus.RAMread      = w_ctl.ram_read;
  assign bus.MDRin        = w_ctl.mdr_in;
  assign bus.MDRout       = w_ctl.mdr_out;
  assign bus.IRin         = w_ctl.ir_in;
  assign bus.InPortout    = w_ctl.in_port_out;
  assign bus.OutPortin    = w_ctl.out_port_in;
  assign bus.Gra          = w_ctl.gra;
  assign bus.Rin          = w_ctl.r_in;
  assign bus.Rout         = w_ctl.r_out;
  assign bus.Run          = w_ctl.run;
  assign bus.Illegal      = w_ctl.illegal;
  assign bus.InstrCount   = r_instr_count;

endmodule

// File: tb/tb_io_control_unit.sv
// ----------------------------------------------------------------------------
// tb_io_control_unit
// Directed stimulus for io_control_unit. Every stimulus cycle pushes the
// hand-derived control word and instruction count expected for that cycle;
// an independent monitor pops one entry each falling edge and compares it
// against what the sequencer is presenting.
// ----------------------------------------------------------------------------
module tb_io_control_unit;
  import io_control_unit_pkg::*;

  typedef logic [19:0] word_t;

  // Bit layout of the observed control word (bench-local).
  localparam word_t M_ILL    = 20'h00001;
  localparam word_t M_RUN    = 20'h00002;
  localparam word_t M_ROUT   = 20'h00004;
  localparam word_t M_RIN    = 20'h00008;
  localparam word_t M_GRA    = 20'h00010;
  localparam word_t M_OPIN   = 20'h00020;
  localparam word_t M_IPOUT  = 20'h00040;
  localparam word_t M_IRIN   = 20'h00080;
  localparam word_t M_MDROUT = 20'h00100;
  localparam word_t M_MDRIN  = 20'h00200;
  localparam word_t M_RAMRD  = 20'h00400;
  localparam word_t M_MDMUX  = 20'h00800;
  localparam word_t M_PCIN   = 20'h01000;
  localparam word_t M_ZLOUT  = 20'h02000;
  localparam word_t M_ZLIN   = 20'h04000;
  localparam word_t M_INCPC  = 20'h08000;
  localparam word_t M_MARIN  = 20'h10000;
  localparam word_t M_PCOUT  = 20'h20000;
  localparam word_t M_OPVAL  = 20'h40000;
  localparam word_t M_IPACK  = 20'h80000;

  localparam word_t W_ZERO    = 20'h00000;
  localparam word_t W_T0      = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZLIN;
  localparam word_t W_T1      = M_RUN | M_ZLOUT | M_PCIN | M_MDMUX | M_RAMRD | M_MDRIN;
  localparam word_t W_T2      = M_RUN | M_MDROUT | M_IRIN;
  localparam word_t W_IN_WAIT = M_RUN | M_IPOUT | M_GRA;
  localparam word_t W_IN_GO   = M_RUN | M_IPOUT | M_GRA | M_RIN | M_IPACK;
  localparam word_t W_OUT     = M_RUN | M_GRA | M_ROUT | M_OPIN | M_OPVAL;
  localparam word_t W_RUN     = M_RUN;
  localparam word_t W_ILL     = M_RUN | M_ILL;

  localparam logic [31:0] IR_IN   = 32'hB200_0000;
  localparam logic [31:0] IR_OUT  = 32'hBA00_0000;
  localparam logic [31:0] IR_NOP  = 32'hD000_0000;
  localparam logic [31:0] IR_HALT = 32'hD800_0000;
  localparam logic [31:0] IR_BAD  = 32'hF800_0000;

  typedef struct {
    word_t       w;
    logic [15:0] cnt;
    string       nm;
  } exp_t;

  logic  clk = 1'b0;
  logic  clear;
  exp_t  exp_q[$];
  exp_t  mon_e;
  word_t mon_act;
  int    n_cmp = 0;
  int    n_bad = 0;

  always #5 clk = ~clk;

  io_control_unit_if u_if ();

  io_control_unit u_dut (
    .i_clock (clk),
    .i_clear (clear),
    .bus     (u_if.master)
  );

  // Drive one cycle of inputs and record what that cycle must show.
  task automatic cyc(input logic clr, input logic [31:0] ir, input logic stp,
                     input logic ipv, input word_t w, input logic [15:0] cnt,
                     input string nm);
    exp_t e;
    clear           = clr;
    u_if.IR         = ir;
    u_if.Stop       = stp;
    u_if.InPortvalid = ipv;
    e.w   = w;
    e.cnt = cnt;
    e.nm  = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // T0..T2 of a fetch; InPortvalid is held high to show it cannot leak an ack.
  task automatic fetch(input logic [15:0] cnt, input logic [31:0] ir, input logic stp);
    cyc(1'b0, ir, stp, 1'b1, W_T0, cnt, "T0");
    cyc(1'b0, ir, stp, 1'b1, W_T1, cnt, "T1");
    cyc(1'b0, ir, stp, 1'b1, W_T2, cnt, "T2");
  endtask

  // Monitor: one comparison per presented control word.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_act = {u_if.InPortack, u_if.OutPortvalid, u_if.PCout, u_if.MARin,
                 u_if.IncPC, u_if.Zlowin, u_if.Zlowout, u_if.PCin,
                 u_if.MDMuxread, u_if.RAMread, u_if.MDRin, u_if.MDRout,
                 u_if.IRin, u_if.InPortout, u_if.OutPortin, u_if.Gra,
                 u_if.Rin, u_if.Rout, u_if.Run, u_if.Illegal};
      n_cmp++;
      if (mon_act !== mon_e.w || u_if.InstrCount !== mon_e.cnt) begin
        n_bad++;
        $display("FAIL %s: ctl=%05h cnt=%0d, required ctl=%05h cnt=%0d",
                 mon_e.nm, mon_act, u_if.InstrCount, mon_e.w, mon_e.cnt);
      end else begin
        $display("ok   %s: ctl=%05h cnt=%0d", mon_e.nm, mon_act, u_if.InstrCount);
      end
    end
  end

  initial begin
    clear            = 1'b1;
    u_if.IR          = '0;
    u_if.Stop        = 1'b0;
    u_if.InPortvalid = 1'b0;
    @(posedge clk);
    #1;

    // Reset and a first fetch; IR=0 decodes as an illegal opcode.
    cyc(1'b1, 32'h0, 1'b0, 1'b0, W_ZERO, 16'd0, "clear_hold");
    cyc(1'b0, 32'h0, 1'b0, 1'b0, W_ZERO, 16'd0, "after_clear");
    fetch(16'd0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, W_ILL, 16'd0, "T3_ir0_illegal");

    // IN with data already valid.
    fetch(16'd1, 32'h0, 1'b0);
    cyc(1'b0, IR_IN, 1'b0, 1'b1, W_IN_GO, 16'd1, "in_ready");

    // IN stalled for three cycles.
    fetch(16'd2, IR_IN, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, IR_IN, 1'b0, 1'b0, W_IN_WAIT, 16'd2, "in_stall");
    end
    cyc(1'b0, IR_IN, 1'b0, 1'b1, W_IN_GO, 16'd2, "in_go");

    // OUT; Stop pulses during the fetch must be ignored.
    fetch(16'd3, IR_IN, 1'b1);
    cyc(1'b0, IR_OUT, 1'b0, 1'b1, W_OUT, 16'd3, "out");

    // Clear during an IN stall.
    fetch(16'd4, IR_OUT, 1'b0);
    cyc(1'b0, IR_IN, 1'b0, 1'b0, W_IN_WAIT, 16'd4, "in_wait");
    cyc(1'b1, IR_IN, 1'b0, 1'b0, W_IN_WAIT, 16'd4, "clear_in_stall");
    cyc(1'b0, IR_IN, 1'b0, 1'b1, W_ZERO, 16'd0, "reset_after_stall");

    // Unsupported opcode.
    fetch(16'd0, IR_IN, 1'b0);
    cyc(1'b0, IR_BAD, 1'b0, 1'b0, W_ILL, 16'd0, "illegal_f8");

    // nop with Stop at its T3 exit -> HALTED.
    fetch(16'd1, IR_BAD, 1'b0);
    cyc(1'b0, IR_NOP, 1'b1, 1'b0, W_RUN, 16'd1, "nop_stop");
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, IR_NOP, 1'b0, 1'b1, W_ZERO, 16'd2, "halted_by_stop");
    end
    cyc(1'b1, IR_NOP, 1'b0, 1'b0, W_ZERO, 16'd2, "clear_from_halt");
    cyc(1'b0, IR_NOP, 1'b0, 1'b0, W_ZERO, 16'd0, "reset");

    // halt instruction, long stay in HALTED, then recovery.
    fetch(16'd0, IR_NOP, 1'b0);
    cyc(1'b0, IR_HALT, 1'b0, 1'b0, W_RUN, 16'd0, "halt_T3");
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, IR_HALT, 1'b0, 1'b1, W_ZERO, 16'd1, "halted");
    end
    cyc(1'b1, IR_HALT, 1'b0, 1'b0, W_ZERO, 16'd1, "clear_halt");
    cyc(1'b0, IR_HALT, 1'b0, 1'b0, W_ZERO, 16'd0, "reset_2");
    fetch(16'd0, IR_HALT, 1'b0);
    cyc(1'b0, IR_NOP, 1'b0, 1'b0, W_RUN, 16'd0, "nop_after_recover");
    cyc(1'b0, IR_NOP, 1'b0, 1'b0, W_T0, 16'd1, "T0_after_nop");

    // Let the monitor drain, bounded.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
